// File: rtl/fetch_op_queue_pkg.sv
// Shared decode definitions for the fetch-to-dispatch op queue: op codes,
// entry width and the bit layout used to pack/unpack queue entries.
package fetch_op_queue_pkg;

  typedef enum logic [4:0] {
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_AUIPC, OP_LUI
  } op_e;

  localparam int PC_W  = 32;
  localparam int OP_W  = 5;
  localparam int REG_W = 5;
  localparam int IMM_W = 32;

  // Entry layout, LSB first: imm | rs2 | rs1 | rd | pred | jalr | use_imm | ls | branch | op | pc
  localparam int OFF_IMM     = 0;
  localparam int OFF_RS2     = OFF_IMM + IMM_W;
  localparam int OFF_RS1     = OFF_RS2 + REG_W;
  localparam int OFF_RD      = OFF_RS1 + REG_W;
  localparam int OFF_PRED    = OFF_RD + REG_W;
  localparam int OFF_JALR    = OFF_PRED + 1;
  localparam int OFF_USE_IMM = OFF_JALR + 1;
  localparam int OFF_LS      = OFF_USE_IMM + 1;
  localparam int OFF_BRANCH  = OFF_LS + 1;
  localparam int OFF_OP      = OFF_BRANCH + 1;
  localparam int OFF_PC      = OFF_OP + OP_W;

  localparam int FOQ_ENTRY_W = OFF_PC + PC_W;

endpackage

// File: rtl/fetch_op_queue_if.sv
// Enqueue (fetch/decode) and dequeue (dispatch) sides of the op queue.
interface fetch_op_queue_if;
  import fetch_op_queue_pkg::*;

  logic             enq_valid;
  logic [PC_W-1:0]  enq_pc;
  logic [OP_W-1:0]  enq_op;
  logic             enq_branch;
  logic             enq_ls;
  logic             enq_use_imm;
  logic [REG_W-1:0] enq_rd;
  logic [REG_W-1:0] enq_rs1;
  logic [REG_W-1:0] enq_rs2;
  logic [IMM_W-1:0] enq_imm;
  logic             enq_jalr;
  logic             enq_pred_taken;
  logic             foq_full;

  logic             deq_valid;
  logic             deq_ready;
  logic [PC_W-1:0]  deq_pc;
  logic [OP_W-1:0]  deq_op;
  logic             deq_branch;
  logic             deq_ls;
  logic             deq_use_imm;
  logic [REG_W-1:0] deq_rd;
  logic [REG_W-1:0] deq_rs1;
  logic [REG_W-1:0] deq_rs2;
  logic [IMM_W-1:0] deq_imm;
  logic             deq_jalr;
  logic             deq_pred_taken;

  modport master (
    output enq_valid, enq_pc, enq_op, enq_branch, enq_ls, enq_use_imm,
           enq_rd, enq_rs1, enq_rs2, enq_imm, enq_jalr, enq_pred_taken,
           deq_ready,
    input  foq_full, deq_valid, deq_pc, deq_op, deq_branch, deq_ls, deq_use_imm,
           deq_rd, deq_rs1, deq_rs2, deq_imm, deq_jalr, deq_pred_taken
  );

  modport slave (
    input  enq_valid, enq_pc, enq_op, enq_branch, enq_ls, enq_use_imm,
           enq_rd, enq_rs1, enq_rs2, enq_imm, enq_jalr, enq_pred_taken,
           deq_ready,
    output foq_full, deq_valid, deq_pc, deq_op, deq_branch, deq_ls, deq_use_imm,
           deq_rd, deq_rs1, deq_rs2, deq_imm, deq_jalr, deq_pred_taken
  );

endinterface

// File: rtl/fetch_op_queue_storage.sv
// Entry array for the op queue: one synchronous write port, one
// asynchronous read port. Contents are never reset; validity lives in the count.
module foq_storage #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 89
) (
  input  logic              clk_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_op_queue.sv
// In-order queue of decoded instructions between fetch/decode and dispatch,
// with one reserve slot for a JALR and full flush on misprediction.
module fetch_op_queue
  import fetch_op_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  fetch_op_queue_if.slave   foq,
  output logic [ADDR_W:0]   count_out
);

  localparam logic [ADDR_W:0] CNT_RESERVE = (ADDR_W+1)'(DEPTH - 1);

  logic [ADDR_W-1:0]      head;
  logic [ADDR_W-1:0]      tail;
  logic [ADDR_W:0]        count;
  logic                   not_empty;
  logic                   has_room;
  logic                   enq_fire;
  logic                   deq_fire;
  logic [FOQ_ENTRY_W-1:0] wr_entry;
  logic [FOQ_ENTRY_W-1:0] rd_entry;
  logic [FOQ_ENTRY_W-1:0] head_entry;

  // The last slot is held back for a JALR the fetch stage commits while stalled.
  assign has_room  = (count < CNT_RESERVE) || ((count == CNT_RESERVE) && foq.enq_jalr);
  assign not_empty = (count != '0);
  assign enq_fire  = rdy_in && !flush_in && foq.enq_valid && has_room;
  assign deq_fire  = rdy_in && !flush_in && not_empty && foq.deq_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq_fire) tail <= tail + ADDR_W'(1);
        if (deq_fire) head <= head + ADDR_W'(1);
        unique case ({enq_fire, deq_fire})
          2'b10:   count <= count + (ADDR_W+1)'(1);
          2'b01:   count <= count - (ADDR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    wr_entry = '0;
    wr_entry[OFF_PC +: PC_W]     = foq.enq_pc;
    wr_entry[OFF_OP +: OP_W]     = foq.enq_op;
    wr_entry[OFF_BRANCH]         = foq.enq_branch;
    wr_entry[OFF_LS]             = foq.enq_ls;
    wr_entry[OFF_USE_IMM]        = foq.enq_use_imm;
    wr_entry[OFF_JALR]           = foq.enq_jalr;
    wr_entry[OFF_PRED]           = foq.enq_pred_taken;
    wr_entry[OFF_RD +: REG_W]    = foq.enq_rd;
    wr_entry[OFF_RS1 +: REG_W]   = foq.enq_rs1;
    wr_entry[OFF_RS2 +: REG_W]   = foq.enq_rs2;
    wr_entry[OFF_IMM +: IMM_W]   = foq.enq_imm;
  end

  foq_storage #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (FOQ_ENTRY_W)
  ) u_storage (
    .clk_in  (clk_in),
    .wr_en   (enq_fire),
    .wr_addr (tail),
    .wr_data (wr_entry),
    .rd_addr (head),
    .rd_data (rd_entry)
  );

  // Stale storage is masked so an empty queue presents all-zero fields.
  assign head_entry = not_empty ? rd_entry : '0;

  assign foq.deq_valid      = not_empty;
  assign foq.deq_pc         = head_entry[OFF_PC +: PC_W];
  assign foq.deq_op         = head_entry[OFF_OP +: OP_W];
  assign foq.deq_branch     = head_entry[OFF_BRANCH];
  assign foq.deq_ls         = head_entry[OFF_LS];
  assign foq.deq_use_imm    = head_entry[OFF_USE_IMM];
  assign foq.deq_jalr       = head_entry[OFF_JALR];
  assign foq.deq_pred_taken = head_entry[OFF_PRED];
  assign foq.deq_rd         = head_entry[OFF_RD +: REG_W];
  assign foq.deq_rs1        = head_entry[OFF_RS1 +: REG_W];
  assign foq.deq_rs2        = head_entry[OFF_RS2 +: REG_W];
  assign foq.deq_imm        = head_entry[OFF_IMM +: IMM_W];

  assign foq.foq_full = (count >= CNT_RESERVE);
  assign count_out    = count;

endmodule
